// File: rtl/mistral_cfg_pkg.sv
// Shared constants, FSM state type and check-word helper for the LUT4 config loader.
package mistral_cfg_pkg;

  localparam logic [3:0]  SYNC    = 4'hA;
  localparam logic [15:0] CHK_KEY = 16'h5A5A;

  typedef enum logic [1:0] {StHdr, StMask, StChk, StWrite} cfg_state_e;

  // Expected check word for a header/mask pair.
  function automatic logic [15:0] frame_chk(input logic [15:0] hdr, input logic [15:0] mask);
    return hdr ^ mask ^ CHK_KEY;
  endfunction

endpackage

// File: rtl/mistral_lut_cfg_loader_if.sv
// Config word stream (valid/ready) between a frame source and the loader.
interface mistral_lut_cfg_loader_if;

  logic [15:0] CFG_DATA;
  logic        CFG_VALID;
  logic        CFG_READY;

  modport master (output CFG_DATA, output CFG_VALID, input CFG_READY);
  modport slave  (input CFG_DATA, input CFG_VALID, output CFG_READY);

endinterface

// File: rtl/mistral_lut4_dyn.sv
// LUT4 with a port-driven mask: A selects first, then B, C and finally D.
module mistral_lut4_dyn (
  input  logic [15:0] MASK,
  input  logic        A,
  input  logic        B,
  input  logic        C,
  input  logic        D,
  output logic        Q
);

  logic [7:0] s_a;
  logic [3:0] s_b;
  logic [1:0] s_c;

  // Binary mux tree; bit index selected is {D,C,B,A}.
  always_comb begin
    for (int i = 0; i < 8; i++) s_a[i] = A ? MASK[2*i+1] : MASK[2*i];
    for (int i = 0; i < 4; i++) s_b[i] = B ? s_a[2*i+1] : s_a[2*i];
    for (int i = 0; i < 2; i++) s_c[i] = C ? s_b[2*i+1] : s_b[2*i];
    Q = D ? s_c[1] : s_c[0];
  end

endmodule

// File: rtl/mistral_lut_cfg_loader.sv
// Runtime-reconfigurable LUT4 bank: checks 3-word config frames into a shadow bank and
// copies the shadow bank to the active bank on COMMIT.
module mistral_lut_cfg_loader
  import mistral_cfg_pkg::*;
#(
  parameter int unsigned NLUT      = 8,
  parameter logic [15:0] INIT_MASK = 16'h0000
) (
  input  logic                   CLK,
  input  logic                   ARST,
  mistral_lut_cfg_loader_if.slave cfg,
  input  logic                   COMMIT,
  input  logic [4*NLUT-1:0]      LUT_IN,
  output logic [NLUT-1:0]        Q,
  output logic [16*NLUT-1:0]     MASKS,
  output logic                   FRAME_OK,
  output logic                   ERR,
  output logic [7:0]             ERR_CNT
);

  cfg_state_e  state_q, state_d;
  logic [15:0] hdr_q, hdr_d;
  logic [15:0] mask_q, mask_d;
  logic [15:0] shadow_q [NLUT];
  logic [15:0] active_q [NLUT];
  logic        err_q;
  logic [7:0]  err_cnt_q;
  logic        ready;
  logic        err_evt;
  logic        addr_ok;

  assign addr_ok = 32'(hdr_q[7:0]) < NLUT;

  // Frame FSM: next state, word capture, handshake and error events.
  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    mask_d   = mask_q;
    ready    = 1'b1;
    FRAME_OK = 1'b0;
    err_evt  = 1'b0;
    case (state_q)
      StHdr: begin
        if (cfg.CFG_VALID) begin
          if (cfg.CFG_DATA[15:12] == SYNC) begin
            hdr_d   = cfg.CFG_DATA;
            state_d = StMask;
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      StMask: begin
        if (cfg.CFG_VALID) begin
          mask_d  = cfg.CFG_DATA;
          state_d = StChk;
        end
      end
      StChk: begin
        if (cfg.CFG_VALID) begin
          if (cfg.CFG_DATA == frame_chk(hdr_q, mask_q) && addr_ok) begin
            state_d = StWrite;
          end else begin
            err_evt = 1'b1;
            state_d = StHdr;
          end
        end
      end
      StWrite: begin
        ready    = 1'b0;
        FRAME_OK = 1'b1;
        state_d  = StHdr;
      end
      default: state_d = StHdr;
    endcase
  end

  assign cfg.CFG_READY = ready;

  // FSM and captured frame words.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= StHdr;
      hdr_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      mask_q  <= mask_d;
    end
  end

  // Shadow/active banks; a commit in the WRITE cycle copies the pre-write shadow.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      for (int i = 0; i < NLUT; i++) begin
        shadow_q[i] <= INIT_MASK;
        active_q[i] <= INIT_MASK;
      end
    end else begin
      for (int i = 0; i < NLUT; i++) begin
        if (state_q == StWrite && hdr_q[7:0] == 8'(i)) shadow_q[i] <= mask_q;
        if (COMMIT) active_q[i] <= shadow_q[i];
      end
    end
  end

  // Sticky error flag and saturating rejected-frame counter.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (err_evt) begin
      err_q <= 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;

  for (genvar i = 0; i < NLUT; i++) begin : g_lut
    assign MASKS[16*i +: 16] = active_q[i];

    mistral_lut4_dyn u_lut (
      .MASK (active_q[i]),
      .A    (LUT_IN[4*i]),
      .B    (LUT_IN[4*i+1]),
      .C    (LUT_IN[4*i+2]),
      .D    (LUT_IN[4*i+3]),
      .Q    (Q[i])
    );
  end

endmodule

// File: tb/tb_mistral_lut_cfg_loader.sv
// Randomized bench for the LUT4 config loader against a frame-level reference model.
module tb_mistral_lut_cfg_loader;

  localparam int unsigned NLUT = 8;
  localparam logic [15:0] INIT = 16'h8000;

  logic              CLK = 1'b0;
  logic              ARST;
  logic              COMMIT;
  logic [4*NLUT-1:0] LUT_IN;
  logic [NLUT-1:0]   Q;
  logic [16*NLUT-1:0] MASKS;
  logic              FRAME_OK;
  logic              ERR;
  logic [7:0]        ERR_CNT;

  mistral_lut_cfg_loader_if cfg_if ();

  mistral_lut_cfg_loader #(
    .NLUT      (NLUT),
    .INIT_MASK (INIT)
  ) dut (
    .CLK      (CLK),
    .ARST     (ARST),
    .cfg      (cfg_if),
    .COMMIT   (COMMIT),
    .LUT_IN   (LUT_IN),
    .Q        (Q),
    .MASKS    (MASKS),
    .FRAME_OK (FRAME_OK),
    .ERR      (ERR),
    .ERR_CNT  (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  // Reference model state.
  logic [15:0] m_shadow [NLUT];
  logic [15:0] m_active [NLUT];
  bit          m_err;
  int          m_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NLUT; i++) begin
      m_shadow[i] = INIT;
      m_active[i] = INIT;
    end
    m_err     = 0;
    m_err_cnt = 0;
  endtask

  task automatic model_error();
    m_err = 1;
    if (m_err_cnt < 255) m_err_cnt++;
  endtask

  function automatic logic [127:0] model_masks();
    logic [127:0] r = '0;
    for (int i = 0; i < NLUT; i++) r[16*i +: 16] = m_active[i];
    return r;
  endfunction

  // Called at a negedge: compare visible state and a random LUT input pattern.
  task automatic check_outputs(input string tag);
    logic [NLUT-1:0] exp_q;
    logic [3:0]      sel;
    check_eq({tag, "_masks"}, MASKS, model_masks());
    check_eq({tag, "_err"}, ERR, m_err);
    check_eq({tag, "_errcnt"}, ERR_CNT, m_err_cnt[7:0]);
    LUT_IN = $urandom;
    #1;
    for (int i = 0; i < NLUT; i++) begin
      sel      = LUT_IN[4*i +: 4];
      exp_q[i] = m_active[i][sel];
    end
    check_eq({tag, "_q"}, Q, exp_q);
  endtask

  task automatic do_reset();
    cfg_if.CFG_VALID = 1'b0;
    COMMIT = 1'b0;
    ARST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    ARST = 1'b0;
    model_reset();
  endtask

  // Offers one word after a random idle gap; returns at the negedge after it is taken.
  task automatic send_word(input logic [15:0] w);
    int gap = $urandom_range(0, 2);
    int guard = 0;
    cfg_if.CFG_VALID = 1'b0;
    repeat (gap) @(negedge CLK);
    cfg_if.CFG_DATA  = w;
    cfg_if.CFG_VALID = 1'b1;
    while (!cfg_if.CFG_READY && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (!cfg_if.CFG_READY) check_eq("ready_timeout", cfg_if.CFG_READY, 1'b1);
    @(negedge CLK);
    cfg_if.CFG_VALID = 1'b0;
  endtask

  task automatic do_commit();
    COMMIT = 1'b1;
    @(negedge CLK);
    COMMIT = 1'b0;
    for (int i = 0; i < NLUT; i++) m_active[i] = m_shadow[i];
  endtask

  // Sends a frame (or just the header if its sync nibble is wrong) and checks the outcome.
  task automatic send_frame(input logic [15:0] hdr, input logic [15:0] mask,
                            input logic [15:0] chk, input bit commit_in_write,
                            input string tag);
    bit ok;
    send_word(hdr);
    if (hdr[15:12] != 4'hA) begin
      model_error();
      check_outputs({tag, "_drop"});
      return;
    end
    send_word(mask);
    send_word(chk);
    ok = (chk == (hdr ^ mask ^ 16'h5A5A)) && (int'(hdr[7:0]) < NLUT);
    check_eq({tag, "_fok"}, FRAME_OK, ok);
    check_eq({tag, "_pre"}, MASKS, model_masks());
    COMMIT = commit_in_write;
    @(negedge CLK);
    COMMIT = 1'b0;
    if (commit_in_write) for (int i = 0; i < NLUT; i++) m_active[i] = m_shadow[i];
    if (ok) m_shadow[hdr[7:0]] = mask;
    else    model_error();
    check_eq({tag, "_fok_off"}, FRAME_OK, 1'b0);
    check_outputs(tag);
  endtask

  initial begin
    logic [15:0] h, m, c;
    cfg_if.CFG_DATA  = '0;
    cfg_if.CFG_VALID = 1'b0;
    COMMIT = 1'b0;
    LUT_IN = '1;
    do_reset();

    // Reset state
    LUT_IN = '1;
    #1;
    check_eq("rst_q", Q, {NLUT{1'b1}});
    check_eq("rst_ready", cfg_if.CFG_READY, 1'b1);
    check_eq("rst_fok", FRAME_OK, 1'b0);
    check_outputs("rst");

    // Directed XOR frame to LUT 3
    h = 16'hA003; m = 16'h6996; c = h ^ m ^ 16'h5A5A;
    send_frame(h, m, c, 0, "xor");
    do_commit();
    check_eq("xor_mask3", MASKS[63:48], 16'h6996);
    LUT_IN = '0;
    LUT_IN[15:12] = 4'b0111;
    #1;
    check_eq("xor_q3", Q[3], 1'b1);
    check_outputs("xor_commit");

    // Bad check word, then a good frame
    send_frame(16'hA003, 16'h6996, 16'h95CE, 0, "badchk");
    check_eq("badchk_cnt", ERR_CNT, 8'd1);
    send_frame(16'hA001, 16'h1234, 16'hA001 ^ 16'h1234 ^ 16'h5A5A, 0, "recover");

    // Out-of-range address and bad sync nibble
    send_frame(16'hA008, 16'hFFFF, 16'hA008 ^ 16'hFFFF ^ 16'h5A5A, 0, "addr8");
    send_frame(16'h1003, 16'h0000, 16'h0000, 0, "sync");

    // Commit in the WRITE cycle takes the pre-write shadow
    send_frame(16'hA005, 16'hC3A5, 16'hA005 ^ 16'hC3A5 ^ 16'h5A5A, 1, "cw");
    do_commit();
    check_outputs("cw2");

    // Random frames with random gaps and commits
    for (int n = 0; n < 40; n++) begin
      h = {4'hA, 4'h0, 8'($urandom_range(0, NLUT + 1))};
      if ($urandom_range(0, 9) == 0) h[15:12] = 4'($urandom_range(0, 9));
      m = 16'($urandom);
      c = h ^ m ^ 16'h5A5A;
      if ($urandom_range(0, 5) == 0) c[$urandom_range(0, 15)] ^= 1'b1;
      send_frame(h, m, c, bit'($urandom_range(0, 1)), "rnd");
      if ($urandom_range(0, 2) == 0) begin
        do_commit();
        check_outputs("rnd_commit");
      end
    end

    // Reset in the middle of a frame
    send_word(16'hA002);
    send_word(16'h5555);
    do_reset();
    check_outputs("midrst");
    send_frame(16'hA002, 16'h0F0F, 16'hA002 ^ 16'h0F0F ^ 16'h5A5A, 0, "postrst");
    do_commit();
    check_outputs("postrst_commit");

    // Error counter saturation
    for (int n = 0; n < 300; n++) begin
      send_word(16'hA001);
      send_word(16'($urandom));
      send_word(16'h0000);
      if (cfg_if.CFG_READY === 1'b0) @(negedge CLK);
      model_error();
    end
    check_eq("sat_cnt", ERR_CNT, 8'd255);
    check_outputs("sat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
